// File: rtl/jpeg_quant_zigzag_pkg.sv
// Shared constants for the quantize/zig-zag block: zig-zag ROM, JPEG Q tables,
// their 16-bit reciprocals and the table-select encodings.
package jpeg_pkg;

   localparam int COEF_W = 10;
   localparam int ROW_W  = 80;

   typedef logic [COEF_W-1:0] coef_t;
   typedef logic [5:0]        idx_t;

   localparam logic [1:0] TBL_LUMA       = 2'd0;
   localparam logic [1:0] TBL_CHROMA     = 2'd1;
   localparam logic [1:0] TBL_BYPASS     = 2'd2;
   localparam logic [1:0] TBL_BYPASS_ALT = 2'd3;

   // Zig-zag position k -> raster address (row*8 + col).
   localparam logic [0:63][5:0] ZZ = {
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   localparam logic [0:63][7:0] Q_LUMA = {
      8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
      8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
      8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
      8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
      8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
      8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
      8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
      8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
   };

   localparam logic [0:63][7:0] Q_CHROMA = {
      8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
      8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
   };

   // Elaboration-time round(65536/Q); never evaluated in hardware.
   function automatic logic [0:63][15:0] build_recip(input logic [0:63][7:0] q);
      logic [0:63][15:0] r;
      logic [31:0]       qq;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         qq   = {24'd0, q[i]};
         r[i] = 16'((32'd65536 + (qq >> 1)) / qq);
      end
      return r;
   endfunction

   localparam logic [0:63][15:0] RECIP_LUMA   = build_recip(Q_LUMA);
   localparam logic [0:63][15:0] RECIP_CHROMA = build_recip(Q_CHROMA);

   function automatic logic [15:0] recip_lookup(input logic [1:0] tbl, input idx_t raster);
      logic [15:0] r;
      case (tbl)
         TBL_LUMA:   r = RECIP_LUMA[raster];
         TBL_CHROMA: r = RECIP_CHROMA[raster];
         default:    r = 16'd0;
      endcase
      return r;
   endfunction

   function automatic logic tbl_is_bypass(input logic [1:0] tbl);
      return (tbl == TBL_BYPASS) || (tbl == TBL_BYPASS_ALT);
   endfunction

endpackage

// File: rtl/jpeg_quant_zigzag_if.sv
// Row-input and coefficient-output handshakes of the quantize/zig-zag block.
interface jpeg_quant_zigzag_if;
   import jpeg_pkg::*;

   logic              row_valid;
   logic              row_ready;
   logic [ROW_W-1:0]  row_data;
   logic [1:0]        tbl_sel;
   logic              out_valid;
   logic              out_ready;
   coef_t             out_data;
   idx_t              out_index;
   logic              out_last;

   modport master (
      output row_valid, row_data, tbl_sel, out_ready,
      input  row_ready, out_valid, out_data, out_index, out_last
   );

   modport slave (
      input  row_valid, row_data, tbl_sel, out_ready,
      output row_ready, out_valid, out_data, out_index, out_last
   );
endinterface

// File: rtl/jpeg_quant_mult.sv
// Combinational sign-magnitude quantizer: round(|coef| * recip / 65536) with
// the sign restored, or the coefficient passed through in bypass.
module jpeg_quant_mult
   import jpeg_pkg::*;
(
   input  coef_t       coef,
   input  logic [15:0] recip,
   input  logic        bypass,
   output coef_t       quant
);

   logic        neg_s;
   logic [10:0] mag_s;
   logic [25:0] prod_s;
   coef_t       q_s;

   // |coef| needs 11 bits so that -512 keeps its magnitude.
   always_comb begin
      neg_s = coef[9];
      if (neg_s) begin
         mag_s = 11'd0 - {coef[9], coef};
      end else begin
         mag_s = {1'b0, coef};
      end
      prod_s = ({15'd0, mag_s} * {10'd0, recip}) + 26'd32768;
      q_s    = 10'(prod_s >> 16);
      if (bypass) begin
         quant = coef;
      end else if (neg_s) begin
         quant = 10'd0 - q_s;
      end else begin
         quant = q_s;
      end
   end

endmodule

// File: rtl/jpeg_quant_zigzag.sv
// Ping-pong 8x8 block buffer: rows in raster order, quantized coefficients
// out in zig-zag order through a single output register.
module jpeg_quant_zigzag
   import jpeg_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   jpeg_quant_zigzag_if.slave bus
);

   coef_t       mem_q [2][64];
   coef_t       mem_d [2][64];
   logic [1:0]  tbl_q [2];
   logic [1:0]  tbl_d [2];
   logic [1:0]  full_q, full_d;
   logic        wr_bank_q, wr_bank_d;
   logic        rd_bank_q, rd_bank_d;
   logic [2:0]  row_cnt_q, row_cnt_d;
   idx_t        rd_cnt_q, rd_cnt_d;
   logic        out_valid_q, out_valid_d;
   coef_t       out_data_q, out_data_d;
   idx_t        out_index_q, out_index_d;
   logic        out_last_q, out_last_d;

   logic        row_acc_s;
   logic        load_s;
   logic        beat_last_s;
   idx_t        raster_s;
   coef_t       coef_s;
   coef_t       quant_s;
   logic [15:0] recip_s;
   logic [1:0]  rd_tbl_s;
   logic        bypass_s;

   assign row_acc_s   = bus.row_valid & ~full_q[wr_bank_q];
   assign load_s      = full_q[rd_bank_q] & (~out_valid_q | bus.out_ready);
   assign beat_last_s = (rd_cnt_q == 6'd63);
   assign raster_s    = ZZ[rd_cnt_q];
   assign coef_s      = mem_q[rd_bank_q][raster_s];
   assign rd_tbl_s    = tbl_q[rd_bank_q];
   assign recip_s     = recip_lookup(rd_tbl_s, raster_s);
   assign bypass_s    = tbl_is_bypass(rd_tbl_s);

   assign bus.row_ready = ~full_q[wr_bank_q];
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_index = out_index_q;
   assign bus.out_last  = out_last_q;

   jpeg_quant_mult u_mult (
      .coef   (coef_s),
      .recip  (recip_s),
      .bypass (bypass_s),
      .quant  (quant_s)
   );

   // Write side: store an accepted row and advance the row counter / bank.
   always_comb begin
      mem_d     = mem_q;
      tbl_d     = tbl_q;
      row_cnt_d = row_cnt_q;
      wr_bank_d = wr_bank_q;
      if (row_acc_s) begin
         for (int c = 0; c < 8; c++) begin
            mem_d[wr_bank_q][{row_cnt_q, 3'(c)}] = bus.row_data[10*c +: 10];
         end
         if (row_cnt_q == 3'd0) begin
            tbl_d[wr_bank_q] = bus.tbl_sel;
         end else begin
            tbl_d[wr_bank_q] = tbl_q[wr_bank_q];
         end
         row_cnt_d = row_cnt_q + 3'd1;
         if (row_cnt_q == 3'd7) begin
            wr_bank_d = ~wr_bank_q;
         end else begin
            wr_bank_d = wr_bank_q;
         end
      end else begin
         row_cnt_d = row_cnt_q;
      end
   end

   // Full flags: the filling bank and the draining bank are always different.
   always_comb begin
      full_d = full_q;
      if (load_s && beat_last_s) begin
         full_d[rd_bank_q] = 1'b0;
      end else begin
         full_d[rd_bank_q] = full_q[rd_bank_q];
      end
      if (row_acc_s && (row_cnt_q == 3'd7)) begin
         full_d[wr_bank_q] = 1'b1;
      end else begin
         full_d[wr_bank_q] = full_d[wr_bank_q];
      end
   end

   // Read side: load the next zig-zag beat whenever the register is free.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      rd_cnt_d    = rd_cnt_q;
      rd_bank_d   = rd_bank_q;
      if (load_s) begin
         out_valid_d = 1'b1;
         out_data_d  = quant_s;
         out_index_d = rd_cnt_q;
         out_last_d  = beat_last_s;
         rd_cnt_d    = rd_cnt_q + 6'd1;
         if (beat_last_s) begin
            rd_bank_d = ~rd_bank_q;
         end else begin
            rd_bank_d = rd_bank_q;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Control state and output register, synchronously cleared.
   always_ff @(posedge clk) begin
      if (!reset) begin
         full_q      <= 2'b00;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         row_cnt_q   <= 3'd0;
         rd_cnt_q    <= 6'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 10'd0;
         out_index_q <= 6'd0;
         out_last_q  <= 1'b0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         row_cnt_q   <= row_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
      end
   end

   // Block storage and per-bank table select are data only, never cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      tbl_q <= tbl_d;
   end

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// Directed bench for jpeg_quant_zigzag: zig-zag order, rounding, streaming,
// backpressure, mid-block reset and first-beat latency.
module tb_jpeg_quant_zigzag;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   jpeg_quant_zigzag_if bus ();

   jpeg_quant_zigzag dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int to_cnt = 0;
   int hold_err = 0;
   int blk [64];

   int zz_tb [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

   int got_data [$];
   int got_idx  [$];
   int got_last [$];
   int got_cyc  [$];

   logic       stall_q = 1'b0;
   logic [9:0] h_data  = 10'd0;
   logic [5:0] h_idx   = 6'd0;
   logic       h_last  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Record accepted beats and flag any change of a stalled beat.
   always @(negedge clk) begin
      if (!reset) begin
         stall_q <= 1'b0;
      end else begin
         if (stall_q && (bus.out_valid !== 1'b1 || bus.out_data !== h_data ||
                         bus.out_index !== h_idx || bus.out_last !== h_last))
            hold_err <= hold_err + 1;
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got_data.push_back(int'($signed(bus.out_data)));
            got_idx.push_back(int'(bus.out_index));
            got_last.push_back(int'(bus.out_last));
            got_cyc.push_back(cyc);
         end
         stall_q <= bus.out_valid && !bus.out_ready;
         h_data  <= bus.out_data;
         h_idx   <= bus.out_index;
         h_last  <= bus.out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive raster row r of blk; tbl_sel on rows 1..7 is deliberately wrong.
   task automatic send_row(input int r, input logic [1:0] ts);
      logic [79:0] d;
      int w;
      for (int c = 0; c < 8; c++) d[10*c +: 10] = 10'(blk[8*r + c]);
      bus.row_valid = 1'b1;
      bus.row_data  = d;
      bus.tbl_sel   = (r == 0) ? ts : (ts ^ 2'b10);
      w = 0;
      while (bus.row_ready !== 1'b1 && w < 1000) begin
         tick();
         w++;
      end
      if (bus.row_ready !== 1'b1) to_cnt++;
      tick();
      bus.row_valid = 1'b0;
   endtask

   task automatic send_block(input logic [1:0] ts);
      for (int r = 0; r < 8; r++) send_row(r, ts);
   endtask

   task automatic wait_beats(input int n);
      int w;
      w = 0;
      while (got_data.size() < n && w < 2000) begin
         tick();
         w++;
      end
      if (got_data.size() < n) to_cnt++;
   endtask

   task automatic clear_blk();
      for (int i = 0; i < 64; i++) blk[i] = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.row_valid = 1'b0;
      bus.row_data  = 80'd0;
      bus.tbl_sel   = 2'd0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      total += 5;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      if (bus.out_data !== 10'd0) begin bad++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
      if (bus.out_index !== 6'd0) begin bad++; $display("FAIL reset_out_index got=%0d exp=0", bus.out_index); end
      if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
      if (bus.row_ready !== 1'b1) begin bad++; $display("FAIL reset_row_ready got=%b exp=1", bus.row_ready); end
   endtask

   task automatic test_latency();
      int start, to0;
      to0 = to_cnt;
      start = got_data.size();
      bus.out_ready = 1'b1;
      clear_blk();
      blk[0] = 100;
      send_block(2'd0);
      total += 4;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL latency_edge_n got=%b exp=0", bus.out_valid); end
      tick();
      if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL latency_edge_n1 got=%b exp=1", bus.out_valid); end
      if (bus.out_index !== 6'd0) begin bad++; $display("FAIL latency_index got=%0d exp=0", bus.out_index); end
      if (bus.out_data !== 10'd6) begin bad++; $display("FAIL latency_data got=%0d exp=6", bus.out_data); end
      wait_beats(start + 64);
      total++;
      if (to_cnt != to0) begin bad++; $display("FAIL latency_timeout got=%0d exp=0", to_cnt - to0); end
   endtask

   task automatic test_zigzag();
      int start, to0;
      to0 = to_cnt;
      start = got_data.size();
      for (int i = 0; i < 64; i++) blk[i] = i;
      send_block(2'd2);
      wait_beats(start + 64);
      total++;
      if (to_cnt != to0) begin bad++; $display("FAIL zigzag_timeout got=%0d exp=0", to_cnt - to0); end
      for (int k = 0; k < 64 && start + k < got_data.size(); k++) begin
         total += 3;
         if (got_data[start+k] !== zz_tb[k]) begin bad++; $display("FAIL zigzag_data k=%0d got=%0d exp=%0d", k, got_data[start+k], zz_tb[k]); end
         if (got_idx[start+k] !== k) begin bad++; $display("FAIL zigzag_index k=%0d got=%0d exp=%0d", k, got_idx[start+k], k); end
         if (got_last[start+k] !== ((k == 63) ? 1 : 0)) begin bad++; $display("FAIL zigzag_last k=%0d got=%0d", k, got_last[start+k]); end
      end
   endtask

   task automatic test_luma_dc();
      int dc_in  [4] = '{100, -24, 24, -512};
      int dc_exp [4] = '{6, -2, 2, -32};
      int start, to0, acc;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         to0 = to_cnt;
         start = got_data.size();
         clear_blk();
         blk[0] = dc_in[t];
         send_block(2'd0);
         wait_beats(start + 64);
         total += 3;
         if (to_cnt != to0) begin bad++; $display("FAIL luma_dc_timeout t=%0d", t); end
         if (got_data.size() >= start + 64) begin
            if (got_data[start] !== dc_exp[t]) begin bad++; $display("FAIL luma_dc in=%0d got=%0d exp=%0d", dc_in[t], got_data[start], dc_exp[t]); end
            acc = 0;
            for (int k = 1; k < 64; k++) if (got_data[start+k] != 0) acc++;
            if (acc !== 0) begin bad++; $display("FAIL luma_dc_ac_zero in=%0d nonzero=%0d exp=0", dc_in[t], acc); end
         end else begin
            bad += 2;
            $display("FAIL luma_dc_missing in=%0d got=%0d beats", dc_in[t], got_data.size() - start);
         end
      end
   endtask

   task automatic test_back_to_back();
      int e [192];
      int start, to0;
      to0 = to_cnt;
      start = got_data.size();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 192; i++) e[i] = 0;
      e[0] = 6;  e[15] = -13;  e[63] = 5;
      e[64] = -1; e[65] = 2;   e[127] = -3;
      for (int k = 0; k < 64; k++) e[128+k] = zz_tb[k]*8 - 256;
      clear_blk();
      blk[0] = 100; blk[5] = -511; blk[63] = 500;
      send_block(2'd0);
      clear_blk();
      blk[0] = -24; blk[1] = 27; blk[63] = -300;
      send_block(2'd1);
      total++;
      if (bus.row_ready !== 1'b0) begin bad++; $display("FAIL b2b_row_ready_after_16 got=%b exp=0", bus.row_ready); end
      for (int i = 0; i < 64; i++) blk[i] = i*8 - 256;
      send_block(2'd2);
      wait_beats(start + 192);
      total++;
      if (to_cnt != to0) begin bad++; $display("FAIL b2b_timeout got=%0d exp=0", to_cnt - to0); end
      for (int i = 0; i < 192 && start + i < got_data.size(); i++) begin
         total += 3;
         if (got_data[start+i] !== e[i]) begin bad++; $display("FAIL b2b_data beat=%0d got=%0d exp=%0d", i, got_data[start+i], e[i]); end
         if (got_idx[start+i] !== i % 64) begin bad++; $display("FAIL b2b_index beat=%0d got=%0d exp=%0d", i, got_idx[start+i], i % 64); end
         if (i > 0 && got_cyc[start+i] !== got_cyc[start+i-1] + 1) begin
            bad++; $display("FAIL b2b_gap beat=%0d cycle=%0d prev=%0d", i, got_cyc[start+i], got_cyc[start+i-1]);
         end
      end
   endtask

   task automatic test_backpressure();
      int start, h0, w;
      start = got_data.size();
      h0 = hold_err;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 64; i++) blk[i] = 300 - 9*i;
      send_block(2'd3);
      w = 0;
      while (got_data.size() < start + 64 && w < 3000) begin
         bus.out_ready = ($urandom_range(0, 99) < 30);
         tick();
         w++;
      end
      bus.out_ready = 1'b1;
      repeat (2) tick();
      total += 2;
      if (got_data.size() < start + 64) begin bad++; $display("FAIL bp_timeout got=%0d beats exp=64", got_data.size() - start); end
      if (hold_err != h0) begin bad++; $display("FAIL bp_hold_stable changes=%0d exp=0", hold_err - h0); end
      for (int k = 0; k < 64 && start + k < got_data.size(); k++) begin
         total += 2;
         if (got_data[start+k] !== 300 - 9*zz_tb[k]) begin bad++; $display("FAIL bp_data k=%0d got=%0d exp=%0d", k, got_data[start+k], 300 - 9*zz_tb[k]); end
         if (got_idx[start+k] !== k) begin bad++; $display("FAIL bp_index k=%0d got=%0d exp=%0d", k, got_idx[start+k], k); end
      end
   endtask

   task automatic test_reset_mid();
      int start, to0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 64; i++) blk[i] = i;
      send_block(2'd2);
      clear_blk();
      for (int i = 0; i < 64; i++) blk[i] = 200 + i;
      for (int r = 0; r < 4; r++) send_row(r, 2'd2);
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      total += 5;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
      if (bus.out_data !== 10'd0) begin bad++; $display("FAIL rstmid_out_data got=%0d exp=0", bus.out_data); end
      if (bus.out_index !== 6'd0) begin bad++; $display("FAIL rstmid_out_index got=%0d exp=0", bus.out_index); end
      if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rstmid_out_last got=%b exp=0", bus.out_last); end
      if (bus.row_ready !== 1'b1) begin bad++; $display("FAIL rstmid_row_ready got=%b exp=1", bus.row_ready); end
      to0 = to_cnt;
      start = got_data.size();
      bus.out_ready = 1'b1;
      clear_blk();
      blk[0] = 100; blk[5] = -511; blk[63] = 500;
      send_block(2'd0);
      wait_beats(start + 64);
      repeat (20) tick();
      total += 2;
      if (to_cnt != to0) begin bad++; $display("FAIL rstmid_timeout got=%0d exp=0", to_cnt - to0); end
      if (got_data.size() !== start + 64) begin bad++; $display("FAIL rstmid_beat_count got=%0d exp=64", got_data.size() - start); end
      if (got_data.size() >= start + 64) begin
         total += 4;
         if (got_data[start] !== 6) begin bad++; $display("FAIL rstmid_k0 got=%0d exp=6", got_data[start]); end
         if (got_idx[start] !== 0) begin bad++; $display("FAIL rstmid_idx0 got=%0d exp=0", got_idx[start]); end
         if (got_data[start+15] !== -13) begin bad++; $display("FAIL rstmid_k15 got=%0d exp=-13", got_data[start+15]); end
         if (got_data[start+63] !== 5) begin bad++; $display("FAIL rstmid_k63 got=%0d exp=5", got_data[start+63]); end
      end
   endtask

   initial begin
      bus.row_valid = 1'b0;
      bus.row_data  = 80'd0;
      bus.tbl_sel   = 2'd0;
      bus.out_ready = 1'b1;
      test_reset();
      test_latency();
      test_zigzag();
      test_luma_dc();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jpeg_quant_zigzag.md
# jpeg_quant_zigzag

- Quantizes 8×8 blocks of 2-D DCT coefficients and reorders them into zig-zag order for the entropy coder.
- Sits directly downstream of the second DCT stage and its transpose memory, in place of the output SRAM write path.
- Accepts one 80-bit row (8 × 10-bit signed coefficients) per handshake and emits one quantized 10-bit coefficient per handshake.
- A ping-pong block buffer decouples the 8-beat input from the 64-beat output.

## Interface
Parameters: none. Tables are fixed constants.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- row_valid  in  1  row_data/tbl_sel valid.
- row_ready  out  1  block can accept a row this cycle.
- row_data  in  80  coefficient for column c at [10c+9:10c], two's complement; rows arrive in order 0..7.
- tbl_sel  in  2  table select, sampled with row 0 only: 0 luma, 1 chroma, 2/3 bypass (no quantization).
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_data  out  10  quantized coefficient, signed.
- out_index  out  6  zig-zag position k, 0..63.
- out_last  out  1  high with k = 63.

## Operation
- **Buffer:** two banks of 64 × 10-bit registers. Per bank: full flag and stored tbl_sel.
- **Write side:**
  - Row accepted when row_valid & row_ready. row_ready = !full[wr_bank]; registered state only, no path from out_ready.
  - row_cnt (0..7) selects raster addresses 8·row_cnt + c.
  - tbl_sel is latched into the bank on row_cnt = 0.
  - On acceptance of row 7: set full[wr_bank], toggle wr_bank, row_cnt wraps to 0.
- **Read side:**
  - rd_cnt k (0..63) addresses raster ZZ[k] of rd_bank while full[rd_bank].
  - Output register loads when full[rd_bank] & (!out_valid | out_ready).
  - When beat k = 63 is loaded: clear full[rd_bank], toggle rd_bank, rd_cnt wraps.
  - The next block streams back-to-back if its bank is already full.
- **Quantization:**
  - mag = |coef| (11-bit, covers −512).
  - q = (mag × recip[tbl][raster] + 2^15) >> 16, giving round-half-away-from-zero.
  - Output = −q if coef < 0, else q.
  - recip = round(65536/Q), 16-bit unsigned; tables are the standard JPEG luma/chroma Q tables.
  - Q ≥ 2 guarantees |q| ≤ 256, so no saturation is required.
  - Bypass: out_data = coef unchanged.
- **Simultaneous events:**
  - Setting full on one bank and clearing full on the other in the same cycle are independent.
  - A bank cleared at edge N accepts rows from cycle N+1.
- **Reset:**
  - Clears full[1:0], wr_bank, rd_bank, row_cnt, rd_cnt.
  - Outputs: out_valid = 0, out_data = 0, out_index = 0, out_last = 0, row_ready = 1 after reset.
  - Buffer contents are not reset.
  - A partial block in flight is discarded. Reset mid-stream drops any undelivered output beat.

## Timing
- Row 7 accepted at edge N: full set at N, first beat (k = 0) loaded at N+1, out_valid high in cycle N+1.
- The multiply and round are combinational into the single output register. Pipeline depth = 1.
- With out_ready held high: 64 consecutive beats, one per cycle, then the next block with no bubble if ready.
- Backpressure: out_data, out_index and out_last hold stable while out_valid & !out_ready.
- Input throughput: 8 rows accepted back-to-back into an empty bank. At most 2 blocks are buffered, after which row_ready = 0.

## Structure
- Package jpeg_pkg:
  - ZZ[64] zig-zag-to-raster ROM (6-bit entries).
  - RECIP_LUMA[64] and RECIP_CHROMA[64] (16-bit).
  - tbl_sel encodings as localparams.
- Sub-module jpeg_quant_mult: combinational coef (10-bit) × recip (16-bit) → rounded signed 10-bit, with bypass input.
- Top holds the banks, counters, full flags and output register.

## Test plan
1. **Zig-zag order:** bypass, raster value = raster index → out_data sequence 0,1,8,16,9,2,3,10,17,24,…,63. out_index 0..63; out_last only on beat 63.
2. **Luma DC rounding (Q = 16, recip = 4096):**
   - DC = 100 → 6.
   - DC = −24 → −2 (half away from zero).
   - DC = 24 → 2.
   - DC = −512 → −32.
3. **Back-to-back blocks:** three blocks streamed with out_ready = 1.
   - row_ready drops after the 16th row.
   - Outputs are 192 consecutive beats with no gap.
   - Each block uses its own latched tbl_sel (luma, chroma, bypass).
4. **Backpressure:** out_ready random 30%. Every beat is held stable until accepted; the output sequence is identical to the unstalled run.
5. **Reset mid-block:** reset low after row 3 of block 0.
   - All outputs return to zero; row_ready = 1.
   - A fresh block then emits correctly, with no remnant beats.
6. **Latency check:** row 7 accepted at edge N with out_ready = 1 → out_valid first high in cycle N+1, beat k = 0.
